addr_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor, successor to the fixed 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, carrying between chunks through a register. Operands enter and results leave through valid/ready handshakes. It serves as the shared arithmetic block for wide datapaths where a single-cycle WIDTH-bit carry chain is too long or too large.

---
 rtl/addr_pkg.sv | 16 +
 rtl/addr_chunk.sv | 14 +
 rtl/addr_seq.sv | 115 +++++++++++
 tb/tb_addr_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/addr_pkg.sv
// Shared definitions for the multi-cycle chunked adder/subtractor.
package addr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width of a counter that must hold 0..nstep-1; never narrower than 1 bit.
    function automatic int step_width(input int nstep);
        int w;
        w = 1;
        while ((1 << w) < nstep) w++;
        return w;
    endfunction

endpackage

// File: rtl/addr_chunk.sv
// Combinational CHUNK-bit adder slice; the only carry chain in the datapath.
module addr_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/addr_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per cycle,
// carry kept in a register, valid/ready on both sides.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// RUN     | processing chunk 'step'
// DONE    | result presented, waiting for out_ready
module addr_seq
    import addr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int SW    = step_width(NSTEP);
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("addr_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [SW-1:0]    step;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic             last;
    int               shamt;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        shamt    = int'(step) * CHUNK;
        a_chunk  = CHUNK'(a_r >> shamt);
        b_chunk  = CHUNK'(b_r >> shamt);
        last     = (step == SW'(NSTEP - 1));
        sum_next = (sum & ~(CMASK << shamt)) | (WIDTH'(s_chunk) << shamt);
    end

    addr_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (s_chunk),
        .cout (c_chunk)
    );

    // rst gates in_ready directly so no operand is taken during reset.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            step     <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        step  <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum   <= sum_next;
                    carry <= c_chunk;
                    if (last) begin
                        state    <= ST_DONE;
                        cout     <= c_chunk;
                        // s_chunk's MSB is the result MSB being written this cycle.
                        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                    (s_chunk[CHUNK-1] != a_r[WIDTH-1]);
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_seq.sv
// Directed and randomized checks of addr_seq (32/4 and 4/4) against an
// integer-arithmetic reference model.
module tb_addr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
    logic [31:0] a, b, sum;
    logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, overflow4;
    logic [3:0]  a4, b4, sum4;

    int tests = 0;
    int fails = 0;

    addr_seq #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    addr_seq #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .cout(cout4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    task automatic model(input int w, input longint ua, input longint ub, input bit ci,
                         input bit sb, output longint s, output bit co, output bit ov);
        longint md, half, sa, sbv, t, r;
        md   = longint'(1) << w;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - md : ua;
        sbv  = (ub >= half) ? ub - md : ub;
        if (sb) begin
            t  = ua - ub + md;
            co = (ua >= ub);
            r  = sa - sbv;
        end else begin
            t  = ua + ub + longint'(ci);
            co = (t >= md);
            r  = sa + sbv + longint'(ci);
        end
        s  = t % md;
        ov = (r < -half) || (r >= half);
    endtask

    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input bit oc,
                          input bit os, input int hold, input string tag);
        int n;
        longint es;
        bit eco, eov;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
        @(negedge clk);
        // Junk with in_valid high while busy must be ignored.
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        check({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(n), 64'd8);
        model(32, longint'(oa), longint'(ob), oc, os, es, eco, eov);
        check({tag, " sum"}, 64'(sum), 64'(es));
        check({tag, " cout"}, 64'(cout), 64'(eco));
        check({tag, " ovf"}, 64'(overflow), 64'(eov));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold sum"}, 64'(sum), 64'(es));
            check({tag, " hold cout"}, 64'(cout), 64'(eco));
            check({tag, " hold ovf"}, 64'(overflow), 64'(eov));
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post valid"}, 64'(out_valid), 64'd0);
        check({tag, " post in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n, seen;
        longint es;
        bit eco, eov;
        logic [3:0] ra, rb;
        bit rc, rs;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst sum", 64'(sum), 64'd0);
        check("rst cout", 64'(cout), 64'd0);
        check("rst ovf", 64'(overflow), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst release in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_wrap");
        check("add_wrap const sum", 64'(sum), 64'h0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, "sub_borrow");
        check("sub_borrow const sum", 64'(sum), 64'hFFFF_FFFE);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, "sub_ovf");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_ovf");
        run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 0, "add_cin");
        check("add_cin const sum", 64'(sum), 64'h31);
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1, 5, "hold");
        run_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 0, "b2b");

        for (int i = 0; i < 10; i++)
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2), "rand");

        // Reset while processing step 3.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst sum", 64'(sum), 64'd0);
        check("midrst in_ready gated", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst no result", 64'(seen), 64'd0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, "after_rst");
        check("after_rst const sum", 64'(sum), 64'h2345_6789);

        // Single-step configuration.
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; sub4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin @(negedge clk); n++; end
        check("w4 latency", 64'(n), 64'd1);
        check("w4 sum", 64'(sum4), 64'h2);
        check("w4 cout", 64'(cout4), 64'd1);
        check("w4 ovf", 64'(overflow4), 64'd1);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check("w4 in_ready", 64'(in_ready4), 64'd1);

        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            a4 = ra; b4 = rb; cin4 = rc; sub4 = rs; in_valid4 = 1'b1;
            @(negedge clk);
            in_valid4 = 1'b0;
            n = 0;
            while (!out_valid4 && n < 20) begin @(negedge clk); n++; end
            model(4, longint'(ra), longint'(rb), rc, rs, es, eco, eov);
            check("w4r latency", 64'(n), 64'd1);
            check("w4r sum", 64'(sum4), 64'(es));
            check("w4r cout", 64'(cout4), 64'(eco));
            check("w4r ovf", 64'(overflow4), 64'(eov));
            out_ready4 = 1'b1;
            @(negedge clk);
            out_ready4 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
